// File: rtl/axi4_lite_req_arbiter.sv
// Round-robin arbiter sharing one strobe-level adapter command port among
// REQ_CNT requesters, each holding a single buffered command slot.
module axi4_lite_req_arbiter #(
    parameter int unsigned REQ_CNT    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [REQ_CNT*DATA_WIDTH-1:0] req_wr_data_i,
    input  logic [REQ_CNT*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [REQ_CNT-1:0]            req_wr_stb_i,
    input  logic [REQ_CNT-1:0]            req_rd_stb_i,
    output logic [REQ_CNT-1:0]            req_busy_o,
    output logic [REQ_CNT-1:0]            req_done_stb_o,
    output logic [DATA_WIDTH-1:0]         req_rd_data_o,
    output logic [DATA_WIDTH-1:0]         adp_wr_data_o,
    output logic [ADDR_WIDTH-1:0]         adp_addr_o,
    output logic                          adp_wr_stb_o,
    output logic                          adp_rd_stb_o,
    input  logic [DATA_WIDTH-1:0]         adp_rd_data_i,
    input  logic                          adp_ready_i,
    input  logic                          adp_done_stb_i
);

    localparam int unsigned IDX_W = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        COMPLETE  = 2'd3
    } state_t;

    state_t                 state;
    logic [REQ_CNT-1:0]     pend;
    logic [REQ_CNT-1:0]     is_wr;
    logic [ADDR_WIDTH-1:0]  slot_addr [REQ_CNT];
    logic [DATA_WIDTH-1:0]  slot_data [REQ_CNT];
    logic [IDX_W-1:0]       grant;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       next_idx;
    logic                   found;
    int unsigned            rr_j;

    assign req_busy_o = pend;

    // First pending slot at or after last_grant+1, wrapping.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        rr_j     = 0;
        for (int unsigned i = 1; i <= REQ_CNT; i++) begin
            rr_j = (32'(last_grant) + i) % REQ_CNT;
            if (!found && pend[IDX_W'(rr_j)]) begin
                found    = 1'b1;
                next_idx = IDX_W'(rr_j);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            pend           <= '0;
            is_wr          <= '0;
            grant          <= '0;
            last_grant     <= IDX_W'(REQ_CNT - 1);
            req_done_stb_o <= '0;
            req_rd_data_o  <= '0;
            adp_wr_data_o  <= '0;
            adp_addr_o     <= '0;
            adp_wr_stb_o   <= 1'b0;
            adp_rd_stb_o   <= 1'b0;
            for (int unsigned k = 0; k < REQ_CNT; k++) begin
                slot_addr[k] <= '0;
                slot_data[k] <= '0;
            end
        end else begin
            req_done_stb_o <= '0;

            // Slot capture; a write wins over a simultaneous read.
            for (int unsigned k = 0; k < REQ_CNT; k++) begin
                if (!pend[k] && (req_wr_stb_i[k] || req_rd_stb_i[k])) begin
                    pend[k]      <= 1'b1;
                    is_wr[k]     <= req_wr_stb_i[k];
                    slot_addr[k] <= req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    slot_data[k] <= req_wr_stb_i[k] ? req_wr_data_i[k*DATA_WIDTH +: DATA_WIDTH]
                                                    : '0;
                end
            end

            case (state)
                IDLE: begin
                    if (found && adp_ready_i) begin
                        grant         <= next_idx;
                        adp_addr_o    <= slot_addr[next_idx];
                        adp_wr_data_o <= slot_data[next_idx];
                        adp_wr_stb_o  <= is_wr[next_idx];
                        adp_rd_stb_o  <= !is_wr[next_idx];
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    adp_wr_stb_o <= 1'b0;
                    adp_rd_stb_o <= 1'b0;
                    state        <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (adp_done_stb_i) begin
                        state <= COMPLETE;
                    end
                end
                COMPLETE: begin
                    req_done_stb_o <= REQ_CNT'(1) << grant;
                    req_rd_data_o  <= is_wr[grant] ? '0 : adp_rd_data_i;
                    pend[grant]    <= 1'b0;
                    last_grant     <= grant;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/axi4_lite_req_arbiter.md
# axi4_lite_req_arbiter

Shares one `axi4_lite_adapter` strobe-level command port among `REQ_CNT` independent requesters, such as register-programming engines and CSR pollers. Each requester posts a single write or read and waits for its private done strobe. The arbiter buffers one command per requester, grants round-robin, and issues exactly one command at a time to the adapter. It returns the completion strobe and read data to the originating requester.

## Interface
Parameters:
- `REQ_CNT`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: data width, equal to the adapter's.
- `ADDR_WIDTH`, 32: address width, equal to the adapter's.

Ports:
- `clk_i`  in  1  single clock; all logic on its rising edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `req_wr_data_i`  in  REQ_CNT*DATA_WIDTH  write data; requester k uses slice [k*DATA_WIDTH +: DATA_WIDTH].
- `req_addr_i`  in  REQ_CNT*ADDR_WIDTH  address; requester k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wr_stb_i`  in  REQ_CNT  one-cycle write request per requester.
- `req_rd_stb_i`  in  REQ_CNT  one-cycle read request per requester.
- `req_busy_o`  out  REQ_CNT  high while requester k has a command pending or in flight.
- `req_done_stb_o`  out  REQ_CNT  one-cycle completion pulse, one-hot.
- `req_rd_data_o`  out  DATA_WIDTH  read data, valid in the `req_done_stb_o` cycle.
- `adp_wr_data_o`  out  DATA_WIDTH  to adapter `wr_data_i`.
- `adp_addr_o`  out  ADDR_WIDTH  to adapter `addr_i`.
- `adp_wr_stb_o`  out  1  to adapter `wr_stb_i`.
- `adp_rd_stb_o`  out  1  to adapter `rd_stb_i`.
- `adp_rd_data_i`  in  DATA_WIDTH  from adapter `rd_data_o`.
- `adp_ready_i`  in  1  from adapter `ready_o`.
- `adp_done_stb_i`  in  1  from adapter `done_stb_o`.

## Operation
- **Slot per requester.** Fields: `pend`, `is_wr`, `addr`, `data`.
  - Capture when `req_wr_stb_i[k]` or `req_rd_stb_i[k]` is high and `req_busy_o[k]` is low.
  - If both strobes are high in the same cycle, the write is taken and the read is dropped.
  - Strobes arriving while busy are ignored; requesters must not strobe while busy.
- `req_busy_o[k] = pend[k]`. `pend[k]` clears on the edge that raises `req_done_stb_o[k]`.
- **Round-robin.** Search starts at `(last_grant + 1) mod REQ_CNT`; the first pending slot wins. `last_grant` resets to `REQ_CNT-1`, so requester 0 has first priority.
- **FSM states:**
  - `IDLE`: if any non-granted slot is pending and `adp_ready_i` is high, latch the grant index and drive the `adp_*` registers from the slot; go to `ISSUE`.
  - `ISSUE` (exactly 1 cycle): exactly one of `adp_wr_stb_o`/`adp_rd_stb_o` is high; go to `WAIT_DONE`.
  - `WAIT_DONE`: on `adp_done_stb_i`, go to `COMPLETE`. `adp_done_stb_i` is ignored in all other states.
  - `COMPLETE` (1 cycle; the adapter's registered read data is now valid). On exiting this state, register:
    - `req_done_stb_o <= onehot(grant)`;
    - `req_rd_data_o <= adp_rd_data_i` for a read, or 0 for a write;
    - `pend[grant] <= 0`;
    - `last_grant <= grant`.
    
    Then go to `IDLE`.
- `adp_addr_o`/`adp_wr_data_o` hold their values from issue until the next grant. `adp_wr_data_o` is 0 for reads.
- A requester may re-strobe in the cycle its done pulse is high; it is captured at that edge.
- **Reset.** All outputs and state go to 0 (`IDLE`, all `pend` cleared, `last_grant = REQ_CNT-1`). Reset mid-transaction aborts silently with no done strobe. The system reset must also reset the adapter.

## Timing
- Request strobe in cycle 0 → earliest `adp_*_stb_o` in cycle 2 → earliest `req_done_stb_o` 2 cycles after `adp_done_stb_i`.
- Back-to-back grants: the next `ISSUE` occurs no earlier than 1 cycle after `COMPLETE`. The `IDLE` cycle is where the done pulse is visible.
- All outputs are registered. No combinational path from `adp_*` inputs to `req_*` outputs.

## Test plan
- **Single write, req 1.** Stimulus: addr 0x10, data 0xDEADBEEF; the adapter model completes 3 cycles after the strobe.
  Required: `adp_wr_stb_o` in cycle 2 with addr 0x10 and data 0xDEADBEEF; `req_done_stb_o = 4'b0010` once; `req_rd_data_o = 0`; `busy[1]` low after the done cycle.
- **Single read, req 2.** Stimulus: addr 0x20; the model returns 0x12345678 via registered `rd_data`.
  Required: `req_done_stb_o = 4'b0100` with `req_rd_data_o = 0x12345678`.
- **Simultaneous reads.** Stimulus: all 4 requesters strobe reads in the same cycle.
  Required: grants in order 0, 1, 2, 3; exactly 4 done pulses, each one-hot and each carrying its own address's data.
- **Fairness.** Stimulus: req 0 re-strobes on every done pulse while req 3 is pending.
  Required: req 3 is granted immediately after the first req 0 completion, not starved.
- **Illegal strobes.** Stimulus: a write and a read strobe in the same cycle on req 0; a strobe on busy req 1.
  Required: only the write is issued for req 0; req 1's second command is dropped, giving exactly one adapter command and one done pulse.
- **Reset during `WAIT_DONE`.** Stimulus: `rst_n_i` low for 1 cycle while in `WAIT_DONE`.
  Required: all outputs are 0 next cycle, no done pulse, and a new request afterwards is serviced normally.
